alu_driver: RTL and testbench

Request-side initiator for the 32-bit datapath ALU. It accepts operation requests (operands, 4-bit ALU control code, tag) through a valid/ready port and buffers them in a small FIFO. It issues each request to the ALU's registered-input interface, waits out the ALU's one-cycle capture latency, and returns result plus zero/cout/overflow flags in order on a valid/ready response port. It sits between the instruction-issue logic (or a testbench sequencer) and the ALU instance.

---
 rtl/alu_driver.sv | 158 +++++++++++++++
 tb/tb_alu_driver.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_driver.sv
// Request FIFO plus issue/wait/respond sequencer in front of a registered-input ALU.
// One operation in flight; responses return in request order.
module alu_driver #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_src1,
  input  logic [31:0]      req_src2,
  input  logic [3:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      alu_src1,
  output logic [31:0]      alu_src2,
  output logic [3:0]       alu_ctrl,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_cout,
  output logic             rsp_overflow,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_illegal,
  output logic             busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 32 + 32 + 4 + TAG_W;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0111: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  endfunction

  state_t           state, state_next;
  logic [EW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_next;
  logic [TAG_W-1:0] tag_q;
  logic             push, pop;
  logic [31:0]      head_src1, head_src2;
  logic [3:0]       head_op;
  logic [TAG_W-1:0] head_tag;

  assign push = req_valid && req_ready;
  assign pop  = (state == ST_IDLE) && (count != '0);
  assign {head_src1, head_src2, head_op, head_tag} = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (pop) state_next = op_legal(head_op) ? ST_ISSUE : ST_RESP;
        else     state_next = ST_IDLE;
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  state_next = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) state_next = ST_IDLE;
        else           state_next = ST_RESP;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // Storage array carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_src1, req_src2, req_op, req_tag};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      req_ready <= (count_next != CW'(DEPTH));
      busy      <= (state_next != ST_IDLE) || (count_next != '0);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Illegal ops bypass the ALU and answer immediately with a zeroed result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_src1     <= 32'd0;
      alu_src2     <= 32'd0;
      alu_ctrl     <= 4'b0000;
      tag_q        <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= 32'd0;
      rsp_zero     <= 1'b0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_tag      <= '0;
      rsp_illegal  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop && op_legal(head_op)) begin
            alu_src1 <= head_src1;
            alu_src2 <= head_src2;
            alu_ctrl <= head_op;
            tag_q    <= head_tag;
          end else if (pop) begin
            rsp_valid    <= 1'b1;
            rsp_result   <= 32'd0;
            rsp_zero     <= 1'b0;
            rsp_cout     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_tag      <= head_tag;
            rsp_illegal  <= 1'b1;
          end
        end
        ST_WAIT: begin
          rsp_valid    <= 1'b1;
          rsp_result   <= alu_result;
          rsp_zero     <= alu_zero;
          rsp_cout     <= alu_cout;
          rsp_overflow <= alu_overflow;
          rsp_tag      <= tag_q;
          rsp_illegal  <= 1'b0;
        end
        ST_RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_driver.sv
// Scoreboard bench for alu_driver with a behavioural registered-input ALU.
// Expected responses are queued at acceptance and checked by an independent monitor.
module tb_alu_driver;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_src1, req_src2;
  logic [3:0]  req_op, req_tag;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero, alu_cout, alu_overflow;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_cout, rsp_overflow, rsp_illegal;
  logic [3:0]  rsp_tag;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic        z, c, o, ill;
    logic [3:0]  tag;
    int          acc;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  alu_driver #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2), .req_op(req_op), .req_tag(req_tag),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout),
    .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_cout(rsp_cout), .rsp_overflow(rsp_overflow),
    .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU model: inputs captured on the clock, outputs combinational from the captured values
  logic [31:0] a_q, b_q;
  logic [3:0]  c_q;
  logic [32:0] sum;
  always @(posedge clk) begin
    a_q <= alu_src1;
    b_q <= alu_src2;
    c_q <= alu_ctrl;
  end
  always_comb begin
    sum          = 33'd0;
    alu_result   = 32'd0;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    case (c_q)
      4'b0000: alu_result = a_q & b_q;
      4'b0001: alu_result = a_q | b_q;
      4'b1100: alu_result = ~(a_q | b_q);
      4'b0010: begin
        sum          = {1'b0, a_q} + {1'b0, b_q};
        alu_result   = sum[31:0];
        alu_cout     = sum[32];
        alu_overflow = (a_q[31] == b_q[31]) && (sum[31] != a_q[31]);
      end
      4'b0110: begin
        sum          = {1'b0, a_q} + {1'b0, ~b_q} + 33'd1;
        alu_result   = sum[31:0];
        alu_cout     = sum[32];
        alu_overflow = (a_q[31] != b_q[31]) && (sum[31] != a_q[31]);
      end
      4'b0111: alu_result = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] res, input logic z, input logic c, input logic o,
                          input logic ill, input logic [3:0] tag, input int lat);
    exp_t e;
    e.res = res; e.z = z; e.c = c; e.o = o; e.ill = ill; e.tag = tag;
    e.acc = cyc + 1; e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Monitor: checks latency at the rising edge of rsp_valid and contents at each handshake
  initial begin
    logic prev_valid;
    exp_t h;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rsp_valid && !prev_valid && exp_q.size() > 0) begin
          h = exp_q[0];
          if (h.lat != 0) chk("latency", 32'(cyc - h.acc), 32'(h.lat));
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp_tag", {28'd0, rsp_tag}, 32'hFFFF_FFFF);
          end else begin
            h = exp_q.pop_front();
            chk("rsp_result", rsp_result, h.res);
            chk("rsp_flags", {29'd0, rsp_zero, rsp_cout, rsp_overflow}, {29'd0, h.z, h.c, h.o});
            chk("rsp_tag", {28'd0, rsp_tag}, {28'd0, h.tag});
            chk("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, h.ill});
          end
        end
      end
      prev_valid = rsp_valid && !rst;
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input logic [31:0] res, input logic z,
                      input logic c, input logic o, input logic ill, input int lat);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b; req_tag = tag;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (req_ready) begin
        push_exp(res, z, c, o, ill, tag, lat);
        @(posedge clk); #1;
        req_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        @(posedge clk); #1;
        return;
      end
    end
    chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_src1 = 32'd0; req_src2 = 32'd0;
    req_op = 4'd0; req_tag = 4'd0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_alu", alu_src1 | alu_src2 | {28'd0, alu_ctrl}, 32'd0);
    chk("reset_rsp", rsp_result | {27'd0, rsp_tag, rsp_illegal}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    send(OP_ADD, 32'd5, 32'd7, 4'd1, 32'd12, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    wait_idle();
    send(OP_SUB, 32'd7, 32'd7, 4'd2, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    wait_idle();
    send(OP_SLT, 32'd3, 32'd5, 4'd3, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    wait_idle();
    send(OP_ADD, 32'h7FFF_FFFF, 32'd1, 4'd4, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 3);
    wait_idle();

    // Backpressure: five fit (one in flight, four queued), the sixth is refused
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_op = OP_ADD; req_src1 = 32'(100 + i); req_src2 = 32'd1;
      req_tag = 4'(i);
      @(negedge clk);
      chk("req_ready_bp", {31'd0, req_ready}, (i < 5) ? 32'd1 : 32'd0);
      if (req_ready) push_exp(32'(101 + i), 1'b0, 1'b0, 1'b0, 1'b0, 4'(i), 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    send(OP_ADD, 32'd105, 32'd1, 4'd5, 32'd106, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    wait_idle();

    send(4'b1111, 32'h1234, 32'h5678, 4'd9, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    wait_idle();
    chk("alu_ctrl_held", {28'd0, alu_ctrl}, {28'd0, OP_ADD});
    chk("alu_src1_held", alu_src1, 32'd105);

    // Hold the response under backpressure
    rsp_ready = 1'b0;
    send(OP_SUB, 32'd10, 32'd3, 4'd3, 32'd7, 1'b0, 1'b1, 1'b0, 1'b0, 3);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_result", rsp_result, 32'd7);
      chk("hold_tag_flags", {24'd0, rsp_tag, rsp_zero, rsp_cout, rsp_overflow, rsp_illegal},
          {24'd0, 4'd3, 4'b0100});
      chk("hold_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("after_hs_valid", {31'd0, rsp_valid}, 32'd0);
    chk("after_hs_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // Reset while the first op is in WAIT with two more queued
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_op = OP_ADD; req_src1 = 32'(i + 1); req_src2 = 32'd2;
      req_tag = 4'(10 + i);
      @(negedge clk);
      chk("req_ready_pre_rst", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("alu_src1_pre_rst", alu_src1, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_alu", alu_src1 | alu_src2 | {28'd0, alu_ctrl}, 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    send(OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 4'd6, 32'h0000_F000, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    wait_idle();
    repeat (10) @(negedge clk);
    chk("queue_empty_end", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
